// File: rtl/hamm_pkg.sv
// Shared definitions for the Hamming(7,4) serial link transmitter.
package hamm_pkg;

  // Codeword positions, transmitted in ascending order
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D1 = 3;
  localparam int POS_P4 = 4;
  localparam int POS_D2 = 5;
  localparam int POS_D3 = 6;
  localparam int POS_D4 = 7;

  typedef logic [1:4] nib_t;
  typedef logic [1:7] cw_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Place data bits and derive the three even-parity bits
  function automatic cw_t hamm_encode(input nib_t d);
    cw_t cw;
    cw         = '0;
    cw[POS_D1] = d[1];
    cw[POS_D2] = d[2];
    cw[POS_D3] = d[3];
    cw[POS_D4] = d[4];
    cw[POS_P1] = d[1] ^ d[2] ^ d[4];
    cw[POS_P2] = d[1] ^ d[3] ^ d[4];
    cw[POS_P4] = d[2] ^ d[3] ^ d[4];
    return cw;
  endfunction

endpackage

// File: rtl/hamm_arbiter_rr.sv
// Two-way round-robin arbiter; the last-served pointer register lives in the caller.
module hamm_arbiter_rr (
  input  logic [1:0] req,
  input  logic       accept,
  input  logic       ptr,
  output logic [1:0] win,
  output logic       ptr_nxt
);

  // On a tie serve the requester that was not served last
  always_comb begin
    win     = req;
    if (req == 2'b11) win = ptr ? 2'b01 : 2'b10;
    ptr_nxt = (accept && (win != 2'b00)) ? win[1] : ptr;
  end

endmodule

// File: rtl/hamming_link_tx.sv
// Transmit-side Hamming(7,4) link controller: arbitrate, encode, serialize.
module hamming_link_tx
  import hamm_pkg::*;
#(
  parameter int BIT_PERIOD = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:4] data0,
  input  logic [1:4] data1,
  input  logic       inj_en,
  input  logic [2:0] inj_pos,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       data_line,
  output logic       strobe
);

  localparam logic [3:0] PER_LAST  = 4'(BIT_PERIOD - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);
  localparam logic       STB_FIRST = (BIT_PERIOD == 1);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [3:0] per_cnt;
  logic [2:7] sr;       // positions not yet placed on data_line
  logic       ptr;
  logic       ptr_nxt;
  logic [1:0] win;
  logic       accept;
  cw_t        flip;
  cw_t        tx_cw;

  assign accept = (state == ST_IDLE) && (req != 2'b00);

  hamm_arbiter_rr u_arb (
    .req    (req),
    .accept (accept),
    .ptr    (ptr),
    .win    (win),
    .ptr_nxt(ptr_nxt)
  );

  // Encode the winning nibble and apply the optional single-bit flip
  always_comb begin
    flip = '0;
    for (int i = 1; i <= 7; i++) flip[i] = inj_en && (inj_pos == 3'(i));
    tx_cw = hamm_encode(win[1] ? data1 : data0) ^ flip;
  end

  // Frame sequencer; strobe is raised one edge early so it lands in the last cycle of each bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      per_cnt   <= '0;
      sr        <= '0;
      ptr       <= 1'b1;
      gnt       <= '0;
      busy      <= 1'b0;
      data_line <= 1'b0;
      strobe    <= 1'b0;
    end else begin
      gnt <= 2'b00;
      ptr <= ptr_nxt;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SHIFT;
            gnt       <= win;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            per_cnt   <= '0;
            sr        <= tx_cw[2:7];
            data_line <= tx_cw[1];
            strobe    <= STB_FIRST;
          end
        end
        ST_SHIFT: begin
          if (per_cnt == PER_LAST) begin
            per_cnt <= '0;
            if (bit_cnt == 3'd6) begin
              data_line <= 1'b0;
              strobe    <= 1'b0;
              if (GAP_CYCLES == 0) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= ST_GAP;
              end
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              data_line <= sr[2];
              sr        <= {sr[3:7], 1'b0};
              strobe    <= STB_FIRST;
            end
          end else begin
            per_cnt <= per_cnt + 4'd1;
            strobe  <= ((per_cnt + 4'd1) == PER_LAST);
          end
        end
        ST_GAP: begin
          if (per_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            per_cnt <= '0;
          end else begin
            per_cnt <= per_cnt + 4'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          data_line <= 1'b0;
          strobe    <= 1'b0;
        end
      endcase
    end
  end

endmodule
